// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction loader: FSM states and
// the byte/word geometry of the instruction memory.
package loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_STRIDE    = 4;

endpackage

// File: rtl/byte_packer.sv
// Assembles four stream bytes MSB-first into one 32-bit word; flags the
// fourth byte so the controller can schedule the write.
module byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        full
);

  logic [31:0] word_r;
  logic [1:0]  cnt_r;

  assign word = word_r;
  // The counter rolls 3->0 on the same edge that completes the word
  assign full = en && (cnt_r == 2'd3);

  // Shift register and byte counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_r <= 32'h0000_0000;
      cnt_r  <= 2'd0;
    end else if (clear) begin
      word_r <= 32'h0000_0000;
      cnt_r  <= 2'd0;
    end else if (en) begin
      word_r <= {word_r[23:0], byte_in};
      cnt_r  <= cnt_r + 2'd1;
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// Loads a program from a byte stream into instruction memory, one 32-bit
// write per four bytes at byte addresses 0, 4, 8, ...
module instruction_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 128,
  parameter int LEN_W      = $clog2(DEPTH/4)+1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_W-1:0]      len,
  input  logic                  s_valid,
  input  logic [7:0]            s_data,
  output logic                  s_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int              WORDS   = DEPTH / BYTES_PER_WORD;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(WORDS);

  state_t                state_r, state_s;
  logic [LEN_W-1:0]      len_r, word_cnt_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic                  done_r, err_r;
  logic                  accept_s, full_s, last_s, len_ok_s;
  logic                  start_ok_s, start_bad_s;
  logic [31:0]           word_s;

  // Moore decodes straight off the state register
  assign s_ready  = (state_r == RECV);
  assign wr_en    = (state_r == WRITE);
  assign busy     = (state_r != IDLE);
  assign accept_s = s_valid && (state_r == RECV);
  assign wr_addr  = addr_r;
  assign wr_data  = word_s;
  assign done     = done_r;
  assign err      = err_r;

  byte_packer u_packer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (start_ok_s),
    .en      (accept_s),
    .byte_in (s_data),
    .word    (word_s),
    .full    (full_s)
  );

  // Next-state and start qualification
  always_comb begin
    state_s     = state_r;
    start_ok_s  = 1'b0;
    start_bad_s = 1'b0;
    len_ok_s    = (len != {LEN_W{1'b0}}) && (len <= MAX_LEN);
    last_s      = ((word_cnt_r + LEN_W'(1)) == len_r);
    case (state_r)
      IDLE: begin
        if (start) begin
          if (len_ok_s) begin
            start_ok_s = 1'b1;
            state_s    = RECV;
          end else begin
            start_bad_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RECV: begin
        if (full_s) begin
          state_s = WRITE;
        end else begin
          state_s = RECV;
        end
      end
      WRITE: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = RECV;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Length, word count, address and status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_r      <= {LEN_W{1'b0}};
      word_cnt_r <= {LEN_W{1'b0}};
      addr_r     <= {ADDR_WIDTH{1'b0}};
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      done_r <= (state_r == WRITE) && last_s;
      err_r  <= start_bad_s;
      if (start_ok_s) begin
        len_r      <= len;
        word_cnt_r <= {LEN_W{1'b0}};
        addr_r     <= {ADDR_WIDTH{1'b0}};
      end else if (state_r == WRITE) begin
        word_cnt_r <= word_cnt_r + LEN_W'(1);
        // Address stays on the last word once the load completes
        if (!last_s) begin
          addr_r <= addr_r + ADDR_WIDTH'(WORD_STRIDE);
        end
      end
    end
  end

endmodule
